// File: rtl/ring_arbiter_if.sv
// Request/grant bundle between requesting engines and the ring arbiter.
// The requesters use the master side and the arbiter uses the slave side.
interface ring_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic [N-1:0] token;
  logic         busy;
  logic         timeout;

  modport master (
    output req, done,
    input  gnt, token, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, token, busy, timeout
  );
endinterface

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token (1000->0100->0010->0001).
// A grant is held until the owner releases it, the owner withdraws, or the hold limit expires.
module ring_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input logic           c,
  input logic           rst,
  ring_arbiter_if.slave bus
);
  localparam int             CW        = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0]  HOLD_LIM  = CW'(HOLD_MAX);
  localparam logic [N-1:0]   TOKEN_RST = {1'b1, {(N-1){1'b0}}};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_n;
  logic [N-1:0]  gnt_q, gnt_n;
  logic [N-1:0]  token_q, token_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          busy_q;
  logic          timeout_q, timeout_n;

  logic [N-1:0]  win;
  int            tok_idx;
  int            idx;
  logic          owner_done;
  logic          withdrawn;
  logic          limit_hit;

  // Search downward from the token index with wrap; the loop runs from the
  // farthest candidate to the nearest so the last hit is the highest priority.
  always_comb begin
    tok_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (token_q[i]) tok_idx = i;
    end
    win = '0;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (tok_idx + N - i) % N;
      if (bus.req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
      end
    end
  end

  assign owner_done = |(bus.done & gnt_q);
  assign withdrawn  = ~|(bus.req & gnt_q);
  assign limit_hit  = (HOLD_MAX != 0) && (cnt_q == HOLD_LIM);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n   = state_q;
    gnt_n     = gnt_q;
    token_n   = token_q;
    cnt_n     = cnt_q;
    timeout_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_n = GRANT;
          gnt_n   = win;
          cnt_n   = CW'(1);
        end
      end
      GRANT: begin
        if (owner_done || withdrawn || limit_hit) begin
          state_n   = IDLE;
          gnt_n     = '0;
          token_n   = {gnt_q[0], gnt_q[N-1:1]};
          cnt_n     = '0;
          timeout_n = limit_hit && !owner_done && !withdrawn;
        end else if (cnt_q != '1) begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it only acts on a clock edge.
  always_ff @(posedge c) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      token_q   <= TOKEN_RST;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      gnt_q     <= gnt_n;
      token_q   <= token_n;
      cnt_q     <= cnt_n;
      busy_q    <= |gnt_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.token   = token_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_ring_arbiter.sv
// Directed bench for ring_arbiter (N=4, HOLD_MAX=8) with hand-computed expectations.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_ring_arbiter;
  localparam int N        = 4;
  localparam int HOLD_MAX = 8;

  logic c;
  logic rst;
  int   n_checks;
  int   n_fail;

  ring_arbiter_if #(.N(N)) bus ();

  ring_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .c   (c),
    .rst (rst),
    .bus (bus)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic b,
                           input logic [3:0] t, input logic to);
    check({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    check({tag, ".busy"},    32'(bus.busy),    32'(b));
    check({tag, ".token"},   32'(bus.token),   32'(t));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
  endtask

  logic [3:0] exp_g [5];
  logic [3:0] exp_t [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    exp_g = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    exp_t = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};

    // Reset held for two edges.
    step();
    step();
    check_out("reset", 4'b0000, 1'b0, 4'b1000, 1'b0);
    rst = 1'b1;
    repeat (10) step();
    check_out("idle10", 4'b0000, 1'b0, 4'b1000, 1'b0);

    // Full rotation with done pulsed one cycle into each grant.
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr%0d.gnt", i), 32'(bus.gnt), 32'(exp_g[i]));
      check($sformatf("rr%0d.busy", i), 32'(bus.busy), 32'd1);
      bus.done = exp_g[i];
      step();
      bus.done = '0;
      check_out($sformatf("rr%0d.rel", i), 4'b0000, 1'b0, exp_t[i], 1'b0);
      if (i == 4) bus.req = '0;
    end

    // Move token to 0010: grant owner 2, then withdraw.
    bus.req = 4'b0100;
    step();
    check_out("w.grant", 4'b0100, 1'b1, 4'b0100, 1'b0);
    bus.req = 4'b0000;
    step();
    check_out("w.rel", 4'b0000, 1'b0, 4'b0010, 1'b0);

    // Token 0010, req 1001: search 1,0 wins before 3.
    bus.req = 4'b1001;
    step();
    check_out("wrap.grant", 4'b0001, 1'b1, 4'b0010, 1'b0);
    bus.done = 4'b0001;
    step();
    bus.done = '0;
    check_out("wrap.rel", 4'b0000, 1'b0, 4'b1000, 1'b0);
    step();
    check_out("wrap.next", 4'b1000, 1'b1, 4'b1000, 1'b0);
    bus.req = '0;
    step();
    check_out("wrap.drop", 4'b0000, 1'b0, 4'b0100, 1'b0);

    // Hold limit: owner 2 never signals done.
    bus.req = 4'b0100;
    for (int i = 1; i <= HOLD_MAX; i++) begin
      step();
      check_out($sformatf("hold%0d", i), 4'b0100, 1'b1, 4'b0100, 1'b0);
    end
    step();
    check_out("hold.expire", 4'b0000, 1'b0, 4'b0010, 1'b1);
    step();
    check_out("hold.regrant", 4'b0100, 1'b1, 4'b0010, 1'b0);
    bus.req = '0;
    step();
    check_out("hold.drop", 4'b0000, 1'b0, 4'b0010, 1'b0);

    // Owner 3: wrong done bit ignored, then done coincides with the limit.
    bus.req = 4'b1000;
    step();
    check_out("own3.grant", 4'b1000, 1'b1, 4'b0010, 1'b0);
    bus.done = 4'b0001;
    step();
    bus.done = '0;
    check_out("own3.wrongdone", 4'b1000, 1'b1, 4'b0010, 1'b0);
    repeat (HOLD_MAX - 2) step();
    check_out("own3.last", 4'b1000, 1'b1, 4'b0010, 1'b0);
    bus.done = 4'b1000;
    step();
    bus.done = '0;
    bus.req  = '0;
    check_out("own3.rel", 4'b0000, 1'b0, 4'b0100, 1'b0);

    // done in IDLE is ignored.
    bus.done = 4'b1111;
    step();
    bus.done = '0;
    check_out("idle.done", 4'b0000, 1'b0, 4'b0100, 1'b0);

    // Reset in the middle of a grant.
    bus.req = 4'b0010;
    step();
    check_out("mid.grant", 4'b0010, 1'b1, 4'b0100, 1'b0);
    rst = 1'b0;
    step();
    check_out("mid.reset", 4'b0000, 1'b0, 4'b1000, 1'b0);
    rst = 1'b1;
    step();
    check_out("mid.regrant", 4'b0010, 1'b1, 4'b1000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
